// File: rtl/conv_job_sched.sv
// conv_job_sched: job queue and launch sequencer in front of the 3x3 binary convolution engine.
// Ports:
//   clk, reset_b (async, active-high)
//   job_valid/job_ready, job_in_base/job_out_base/job_wbase, job_tag : host descriptor push
//   flush                                        : drop all queued, not-yet-launched jobs
//   eng_run, eng_busy, eng_in_base/eng_out_base/eng_wbase : engine sequencing
//   done_pulse, done_tag, jobs_done              : completion reporting
//   q_level                                      : queued entries, excluding the active job
//   err_timeout                                  : sticky watchdog error
// Optional feature: define CONV_SCHED_WDOG_EN to enable the WAIT/RUN watchdog.
module conv_job_sched #(
  parameter int DEPTH       = 4,
  parameter int AW          = 12,
  parameter int WDOG_CYCLES = 4096
) (
  input  logic                     clk,
  input  logic                     reset_b,
  input  logic                     job_valid,
  output logic                     job_ready,
  input  logic [AW-1:0]            job_in_base,
  input  logic [AW-1:0]            job_out_base,
  input  logic [AW-1:0]            job_wbase,
  input  logic [3:0]               job_tag,
  input  logic                     flush,
  output logic                     eng_run,
  input  logic                     eng_busy,
  output logic [AW-1:0]            eng_in_base,
  output logic [AW-1:0]            eng_out_base,
  output logic [AW-1:0]            eng_wbase,
  output logic                     done_pulse,
  output logic [3:0]               done_tag,
  output logic [7:0]               jobs_done,
  output logic [$clog2(DEPTH):0]   q_level,
  output logic                     err_timeout
);
  localparam int PW = $clog2(DEPTH);
  localparam int JW = 3*AW + 4;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || WDOG_CYCLES < 2 || WDOG_CYCLES > 65536) begin : g_bad_param
    $error("conv_job_sched: illegal parameter value");
  end

  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT_BUSY, RUN, DONE} state_t;

  state_t        state, state_nx;
  logic [JW-1:0] mem [DEPTH];
  logic [JW-1:0] act;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          push, pop, timeout;

  // Descriptor layout: {in_base, out_base, wbase, tag}
  assign eng_in_base  = act[JW-1 -: AW];
  assign eng_out_base = act[2*AW+3 -: AW];
  assign eng_wbase    = act[AW+3 -: AW];
  assign eng_run      = state == LAUNCH;
  assign done_pulse   = state == DONE;
  // Gated by reset so every output reads 0 while reset is held.
  assign job_ready    = q_level != (PW+1)'(DEPTH) && !flush && !reset_b;
  assign push         = job_valid && job_ready;
  assign pop          = state == IDLE && q_level != '0;

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:      state_nx = pop ? LAUNCH : IDLE;
      LAUNCH:    state_nx = WAIT_BUSY;
      WAIT_BUSY: state_nx = timeout ? DONE : eng_busy ? RUN : WAIT_BUSY;
      RUN:       state_nx = (timeout || !eng_busy) ? DONE : RUN;
      DONE:      state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {job_in_base, job_out_base, job_wbase, job_tag};
  end

  always_ff @(posedge clk or posedge reset_b) begin
    if (reset_b) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      q_level   <= '0;
      act       <= '0;
      done_tag  <= '0;
      jobs_done <= '0;
    end else begin
      state <= state_nx;
      if (flush) begin
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        q_level <= '0;
      end else begin
        wr_ptr  <= wr_ptr + PW'(push);
        rd_ptr  <= rd_ptr + PW'(pop);
        q_level <= q_level + (PW+1)'(push) - (PW+1)'(pop);
      end
      if (pop) act <= mem[rd_ptr];
      // Completion data is captured on entry to DONE so it is valid with done_pulse.
      if (state_nx == DONE && state != DONE) begin
        done_tag  <= act[3:0];
        jobs_done <= jobs_done + 8'd1;
      end
    end
  end

`ifdef CONV_SCHED_WDOG_EN
  logic [15:0] wdog;
  assign timeout = (state == WAIT_BUSY || state == RUN) && wdog == 16'(WDOG_CYCLES - 1);
  always_ff @(posedge clk or posedge reset_b) begin
    if (reset_b) begin
      wdog        <= '0;
      err_timeout <= 1'b0;
    end else begin
      wdog        <= state == LAUNCH ? '0 : (state == WAIT_BUSY || state == RUN) ? wdog + 16'd1 : wdog;
      err_timeout <= flush ? 1'b0 : timeout ? 1'b1 : err_timeout;
    end
  end
`else
  assign timeout     = 1'b0;
  assign err_timeout = 1'b0;
`endif
endmodule
